// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment codes, FSM states and decode result type for seg7_reader
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h01;
  localparam logic [6:0] SEG_1     = 7'h4F;
  localparam logic [6:0] SEG_2     = 7'h12;
  localparam logic [6:0] SEG_3     = 7'h06;
  localparam logic [6:0] SEG_4     = 7'h4C;
  localparam logic [6:0] SEG_5     = 7'h24;
  localparam logic [6:0] SEG_6     = 7'h60;
  localparam logic [6:0] SEG_7     = 7'h0F;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h0C;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {WAIT, EMIT, DONE} state_e;

  // valid covers both a digit and a blank; digit is 0 for a blank
  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] digit;
  } digit_res_t;

  function automatic logic [6:0] bcd_value(input logic [3:0] tens, input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// rtl/seg7_digit_decode.sv - active-low 7-segment code to digit/blank/invalid
import seg7_pkg::*;

module seg7_digit_decode (
  input  logic [6:0] code_i,
  output digit_res_t res_o
);

  always_comb begin
    res_o = '{valid: 1'b1, blank: 1'b0, digit: 4'd0};
    case (code_i)
      SEG_0:     res_o.digit = 4'd0;
      SEG_1:     res_o.digit = 4'd1;
      SEG_2:     res_o.digit = 4'd2;
      SEG_3:     res_o.digit = 4'd3;
      SEG_4:     res_o.digit = 4'd4;
      SEG_5:     res_o.digit = 4'd5;
      SEG_6:     res_o.digit = 4'd6;
      SEG_7:     res_o.digit = 4'd7;
      SEG_8:     res_o.digit = 4'd8;
      SEG_9:     res_o.digit = 4'd9;
      SEG_BLANK: res_o.blank = 1'b1;
      default:   res_o.valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// rtl/seg7_reader.sv - debounced two-digit 7-segment reader with valid/ready output and error count
import seg7_pkg::*;

module seg7_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_hi,
  input  logic [6:0] seg_lo,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_tens,
  output logic [3:0] out_ones,
  output logic [6:0] out_value,
  output logic       out_blank,
  output logic       err_pulse,
  output logic [7:0] err_count
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  logic [13:0] sample_q, sample_d, frame_q;
  logic [7:0]  cnt_q, cnt_d;
  state_e      state_q;
  digit_res_t  hi_res, lo_res;
  logic        sample_changed, frame_ok;

  logic       out_valid_q, out_blank_q, err_pulse_q;
  logic [3:0] out_tens_q, out_ones_q;
  logic [6:0] out_value_q;
  logic [7:0] err_count_q;

  seg7_digit_decode u_dec_hi (.code_i(sample_q[13:7]), .res_o(hi_res));
  seg7_digit_decode u_dec_lo (.code_i(sample_q[6:0]),  .res_o(lo_res));

  assign sample_d       = {seg_hi, seg_lo};
  assign sample_changed = (sample_d != sample_q);
  assign frame_ok       = hi_res.valid && lo_res.valid && (hi_res.blank == lo_res.blank);

  always_comb begin
    cnt_d = cnt_q;
    if (sample_changed)
      cnt_d = 8'd1;
    else if (cnt_q >= STABLE_MAX)
      cnt_d = STABLE_MAX;
    else
      cnt_d = cnt_q + 8'd1;
  end

  // Acting on cnt_d lets the frame be taken on the edge that completes the stable run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q    <= {SEG_BLANK, SEG_BLANK};
      frame_q     <= {SEG_BLANK, SEG_BLANK};
      cnt_q       <= 8'd0;
      state_q     <= WAIT;
      out_valid_q <= 1'b0;
      out_tens_q  <= 4'd0;
      out_ones_q  <= 4'd0;
      out_value_q <= 7'd0;
      out_blank_q <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      sample_q    <= sample_d;
      cnt_q       <= cnt_d;
      err_pulse_q <= 1'b0;
      case (state_q)
        WAIT: begin
          if (cnt_d == STABLE_MAX) begin
            if (frame_ok) begin
              out_valid_q <= 1'b1;
              out_tens_q  <= hi_res.digit;
              out_ones_q  <= lo_res.digit;
              out_value_q <= bcd_value(hi_res.digit, lo_res.digit);
              out_blank_q <= hi_res.blank;
              frame_q     <= sample_q;
              state_q     <= EMIT;
            end else begin
              err_pulse_q <= 1'b1;
              if (err_count_q != 8'hFF)
                err_count_q <= err_count_q + 8'd1;
              state_q <= DONE;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (sample_d == frame_q) begin
              state_q <= DONE;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 8'd1;
            end
          end
        end
        DONE: begin
          if (sample_changed)
            state_q <= WAIT;
        end
        default: state_q <= WAIT;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_tens  = out_tens_q;
  assign out_ones  = out_ones_q;
  assign out_value = out_value_q;
  assign out_blank = out_blank_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule
